// File: rtl/MipsDecodePkg.sv
// MipsDecodePkg: opcodes and the decoded-entry record shared by the decode stage.
package MipsDecodePkg;
    localparam int PC_MAX_W = 64;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LWR   = 6'h26;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SWR   = 6'h2E;

    typedef struct packed {
        logic                valid;
        logic [15:0]         imm16;
        logic                extSign;
        logic                isLui;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          rd;
        logic [PC_MAX_W-1:0] pc;
        logic                illegal;
    } entry_t;
endpackage

// File: rtl/id_imm_decode.sv
// id_imm_decode: combinational instruction -> decoded entry (fields, imm16, extend mode).
module id_imm_decode
    import MipsDecodePkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output entry_t          o_entry
);
    logic [5:0] w_op;
    logic       w_zext;
    logic       w_sext;
    logic       w_noimm;

    assign w_op    = i_instr[31:26];
    assign w_zext  = w_op inside {[OP_ANDI:OP_LUI]};
    assign w_sext  = w_op inside {[OP_BEQ:OP_SLTIU], [OP_LB:OP_LWR], [OP_SB:OP_SWR]};
    assign w_noimm = w_op inside {OP_RTYPE, OP_J, OP_JAL};

    always_comb begin
        o_entry         = '0;
        o_entry.valid   = 1'b1;
        o_entry.imm16   = w_noimm ? 16'h0 : i_instr[15:0];
        o_entry.extSign = w_sext;
        o_entry.isLui   = w_op == OP_LUI;
        o_entry.rs      = i_instr[25:21];
        o_entry.rt      = i_instr[20:16];
        o_entry.rd      = i_instr[15:11];
        o_entry.pc      = PC_MAX_W'(i_pc);
        o_entry.illegal = !(w_zext || w_sext || w_noimm);
    end
endmodule

// File: rtl/id_imm_stage.sv
// id_imm_stage: 2-entry skid buffer of decoded instructions feeding the extend unit.
// ID_ILLEGAL_OP_EN adds the registered outIllegal flag for unlisted opcodes.
module id_imm_stage
    import MipsDecodePkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [31:0]     inInstr,
    input  logic [PC_W-1:0] inPc,
    output logic            outValid,
    input  logic            outReady,
    output logic [15:0]     outImm16,
    output logic            outExtSign,
    output logic            outIsLui,
    output logic [4:0]      outRs,
    output logic [4:0]      outRt,
    output logic [4:0]      outRd,
    output logic [PC_W-1:0] outPc
`ifdef ID_ILLEGAL_OP_EN
    ,
    output logic            outIllegal
`endif
);
    entry_t r_m;
    entry_t r_s;
    entry_t w_in;
    entry_t w_m_nxt;
    entry_t w_s_nxt;
    logic   w_acc;
    logic   w_con;
    logic   w_unused;

    id_imm_decode #(.PC_W(PC_W)) u_decode (
        .i_instr(inInstr),
        .i_pc   (inPc),
        .o_entry(w_in)
    );

    assign inReady = !r_s.valid;
    assign w_acc   = inValid && inReady;
    assign w_con   = r_m.valid && outReady;

    always_comb begin
        w_m_nxt = r_m;
        w_s_nxt = r_s;
        if (w_con) begin
            w_m_nxt = r_s.valid ? r_s : (w_acc ? w_in : '0);
            w_s_nxt = (r_s.valid && w_acc) ? w_in : '0;
        end else if (w_acc) begin
            w_m_nxt = r_m.valid ? r_m : w_in;
            w_s_nxt = r_m.valid ? w_in : r_s;
        end
    end

    // Flush clears the data as well as the valid bits so outIllegal drops too.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            r_m <= w_m_nxt;
            r_s <= w_s_nxt;
        end
    end

    assign outValid   = r_m.valid;
    assign outImm16   = r_m.imm16;
    assign outExtSign = r_m.extSign;
    assign outIsLui   = r_m.isLui;
    assign outRs      = r_m.rs;
    assign outRt      = r_m.rt;
    assign outRd      = r_m.rd;
    assign outPc      = r_m.pc[PC_W-1:0];
    assign w_unused   = ^r_m;
`ifdef ID_ILLEGAL_OP_EN
    assign outIllegal = r_m.illegal;
`endif
endmodule
